// File: rtl/pwm_dac.sv
// pwm_dac: PWM DAC output stage. Scales an 8-bit NCO sample by an 8-bit gain,
// latches the result as the duty cycle once per PWM period and drives a
// complementary high-side / low-side pair from a free-running period counter.
//
// Parameters:
//   PERIOD_MAX - last counter value; one PWM period is PERIOD_MAX+1 clocks
//   DEADBAND   - dead-time length in clocks (PWM_DEADBAND_EN builds only)
//
// Ports:
//   clk             - single clock, rising edge
//   rst_n           - asynchronous active-low reset
//   sys_en          - run enable
//   sample_i        - unsigned waveform sample from the upstream NCO
//   gain_i          - unsigned amplitude scale
//   pwm_hi_o        - high-side drive (registered)
//   pwm_lo_o        - low-side drive (registered)
//   period_strobe_o - one-cycle pulse on the last count of each period;
//                     also serves as the sample request to the NCO
//
// Build option:
//   PWM_DEADBAND_EN - when defined, inserts DEADBAND clocks of dead time
//                     (both outputs low) after every raw PWM edge.
module pwm_dac #(
  parameter int PERIOD_MAX = 254,
  parameter int DEADBAND   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sys_en,
  input  logic [7:0] sample_i,
  input  logic [7:0] gain_i,
  output logic       pwm_hi_o,
  output logic       pwm_lo_o,
  output logic       period_strobe_o
);

  localparam int CW   = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX + 1) : 1;
  // Compare width wide enough for both the counter and the 8-bit duty value.
  localparam int CMPW = (CW > 8) ? CW : 8;
  localparam logic [CW-1:0] COUNT_LAST = CW'(PERIOD_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  // A negative dead time has no meaning; this empty block only marks it.
  if (DEADBAND < 0) begin : g_deadband_negative
  end

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] count;
  logic [7:0]    duty_q;
  logic [7:0]    scaled;
  logic          active;
  logic          period_end;
  logic          go_idle;
  logic          drive_en;
  logic          raw;
  logic          hi_next;
  logic          lo_next;

  // High byte of the 16-bit product, truncated.
  assign scaled = 8'(({8'd0, sample_i} * {8'd0, gain_i}) >> 8);

  assign active     = (state != IDLE);
  assign period_end = active && (count == COUNT_LAST);
  // A stopped generator leaves only at the end of a full period.
  assign go_idle    = (state == STOP) && !sys_en && period_end;
  // Output register is cleared on the edge that enters IDLE so the first
  // IDLE cycle already shows both drives low.
  assign drive_en   = active && !go_idle;
  assign raw        = CMPW'(count) < CMPW'(duty_q);

  assign period_strobe_o = period_end;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sys_en) state_next = RUN;
      RUN:     if (!sys_en) state_next = STOP;
      STOP: begin
        if (sys_en)          state_next = RUN;
        else if (period_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, period counter and duty latch. The duty value is sampled either on
  // the IDLE->RUN edge or on the last count of a period, never mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      duty_q <= '0;
    end else begin
      state <= state_next;
      if (!active || period_end) count <= '0;
      else                       count <= count + 1'b1;
      if ((state == IDLE && sys_en) || period_end) duty_q <= scaled;
    end
  end

`ifdef PWM_DEADBAND_EN
  localparam int DW = (DEADBAND > 0) ? $clog2(DEADBAND + 1) : 1;

  logic [DW-1:0] dead_q;
  logic [DW-1:0] dead_next;
  logic          raw_q;

  // Any raw edge (re)loads the dead counter; outputs stay low until the
  // counter would be zero in the cycle they are presented.
  always_comb begin
    dead_next = '0;
    if (active) begin
      if (raw != raw_q)     dead_next = DW'(DEADBAND);
      else if (dead_q != 0) dead_next = dead_q - 1'b1;
    end
    hi_next = drive_en && raw && (dead_next == 0);
    lo_next = drive_en && !raw && (dead_next == 0);
  end

  // Dead-time tracking state; cleared whenever the generator is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_q <= '0;
      raw_q  <= 1'b0;
    end else begin
      dead_q <= dead_next;
      raw_q  <= active ? raw : 1'b0;
    end
  end
`else
  always_comb begin
    hi_next = drive_en && raw;
    lo_next = drive_en && !raw;
  end
`endif

  // Registered drive pair, one clock behind raw PWM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_hi_o <= 1'b0;
      pwm_lo_o <= 1'b0;
    end else begin
      pwm_hi_o <= hi_next;
      pwm_lo_o <= lo_next;
    end
  end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 SHALL have parameter PERIOD_MAX, default 254: last count of the PWM period, giving a period of PERIOD_MAX+1 clocks.
REQ-002 SHALL have parameter DEADBAND, default 4: dead-time length in clocks; used only when PWM_DEADBAND_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port sys_en, input, 1 bit: run enable.
REQ-006 SHALL have port sample_i, input, 8 bits: unsigned waveform sample from the upstream NCO data_o.
REQ-007 SHALL have port gain_i, input, 8 bits: unsigned amplitude scale.
REQ-008 SHALL have port pwm_hi_o, output, 1 bit: high-side drive.
REQ-009 SHALL have port pwm_lo_o, output, 1 bit: low-side drive.
REQ-010 SHALL have port period_strobe_o, output, 1 bit: one-cycle pulse at each period end; doubles as the sample request.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and STOP.
REQ-012 In IDLE, SHALL hold the count at 0, drive both PWM outputs 0 and drive period_strobe_o 0.
REQ-013 SHALL move IDLE->RUN on sys_en=1, loading duty_q from the current scaled sample in the same edge.
REQ-014 SHALL move RUN->STOP on sys_en=0.
REQ-015 SHALL move STOP->RUN on sys_en=1, without restarting the count.
REQ-016 SHALL move STOP->IDLE in the cycle count==PERIOD_MAX, so a period is never truncated.
REQ-017 In RUN and STOP, the period counter SHALL increment by 1 per clock and wrap from PERIOD_MAX to 0.
REQ-018 The scaled sample SHALL be bits [15:8] of the 16-bit unsigned product sample_i*gain_i, with no rounding.
REQ-019 duty_q SHALL update only in the cycle count==PERIOD_MAX (in RUN or STOP), with the scaled value present in that cycle; sample changes mid-period SHALL have no effect.
REQ-020 period_strobe_o SHALL be 1 exactly in the cycles where count==PERIOD_MAX in RUN or STOP.
REQ-021 Raw PWM SHALL be (count < duty_q); duty_q=0 gives a constant low, duty_q>PERIOD_MAX gives a constant high.
REQ-022 pwm_hi_o and pwm_lo_o SHALL be registered, one clock behind raw PWM.
REQ-023 pwm_hi_o and pwm_lo_o SHALL never both be 1.
REQ-024 On the first clock in IDLE after STOP, both outputs SHALL be 0.

Reset
REQ-025 While rst_n=0, SHALL force: state IDLE, count 0, duty_q 0, dead counter 0, and all outputs 0, asynchronously.
REQ-026 Reset asserted mid-period SHALL abort the period immediately, with no completion.
REQ-027 After rst_n deasserts, SHALL restart from IDLE on the next sys_en=1.

Configuration
REQ-028 SHALL use the macro PWM_DEADBAND_EN to select dead-time insertion.
REQ-029 With PWM_DEADBAND_EN defined: each raw PWM edge SHALL load the dead counter with DEADBAND.
REQ-030 With PWM_DEADBAND_EN defined: both outputs SHALL be 0 while the dead counter is nonzero.
REQ-031 With PWM_DEADBAND_EN defined: the dead counter SHALL be reloaded if raw PWM toggles again during dead time.
REQ-032 With PWM_DEADBAND_EN defined: once the dead counter reaches 0, pwm_hi_o SHALL equal raw and pwm_lo_o SHALL equal NOT raw.
REQ-033 Without PWM_DEADBAND_EN: in RUN/STOP, pwm_hi_o SHALL equal raw and pwm_lo_o SHALL equal NOT raw, with no dead counter logic present.

Verification
REQ-034 Reset, then sys_en=1 with sample_i=128 and gain_i=255 -> duty_q=127; pwm_hi_o high for 127 clocks and low for 128 per 255-clock period; strobe every 255 clocks.
REQ-035 sample_i=200 and gain_i=0 -> pwm_hi_o constantly 0 and pwm_lo_o constantly 1 (no-deadband build).
REQ-036 sample_i changes from 50 to 250 at count=100 with gain_i=255 -> current period keeps duty 49; next period uses duty 249.
REQ-037 sys_en dropped at count=30 -> counting continues to 254 with strobe asserted; IDLE entered with outputs 0 on the next clock; re-asserting sys_en at count=200 instead -> no interruption.
REQ-038 PWM_DEADBAND_EN build with DEADBAND=4 and duty 100 -> both outputs 0 for 4 clocks after each raw edge; pwm_hi_o and pwm_lo_o never both 1 across 10 periods.
REQ-039 rst_n pulled low at count=77 -> all outputs 0 in the same cycle, and state IDLE after release.
